// File: rtl/delay_eye_scan.sv
// Eye-centering sweep for the DAC data-path ODELAY. Steps the tap across its range,
// grades each tap over a pattern-check window, then commands the centre of the longest passing run.
module delay_eye_scan #(
  parameter int STEP    = 8,
  parameter int MAX_TAP = 511,
  parameter int SETTLE  = 64,
  parameter int SAMPLE  = 256,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk_125m,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ready,
  input  logic [8:0] delay_monitor,
  input  logic       pattern_ok,
  output logic [8:0] delay_value,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [8:0] best_delay,
  output logic [9:0] eye_len
);

  localparam int CW = $clog2((SETTLE > SAMPLE ? SETTLE : SAMPLE) + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SET, S_APPLY, S_SETTLE, S_SAMPLE, S_EVAL, S_CENTER, S_FINAL, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [8:0]      tap_q, tap_d;
  logic [8:0]      restore_q, restore_d;
  logic [8:0]      delay_value_q, delay_value_d;
  logic            busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [8:0]      best_delay_q, best_delay_d;
  logic [9:0]      eye_len_q, eye_len_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pass_q, pass_d;
  logic            run_open_q, run_open_d;
  logic [8:0]      run_start_q, run_start_d, best_start_q, best_start_d;
  logic [9:0]      run_len_q, run_len_d, best_len_q, best_len_d;

  // Run bookkeeping for the tap just graded, evaluated before the state decode uses it.
  logic [9:0]      next_tap;
  logic            last_point;
  logic            cand_open, close_run;
  logic [8:0]      cand_start;
  logic [9:0]      cand_len;
  logic [15:0]     span, centre;
  logic [6:0]      unused_centre_hi;
  logic [8:0]      centre_tap;

  always_comb begin
    next_tap   = {1'b0, tap_q} + 10'(STEP);
    last_point = next_tap > 10'(MAX_TAP);
    if (pass_q) begin
      cand_open  = 1'b1;
      cand_start = run_open_q ? run_start_q : tap_q;
      cand_len   = run_open_q ? run_len_q + 10'd1 : 10'd1;
    end else begin
      cand_open  = run_open_q;
      cand_start = run_start_q;
      cand_len   = run_len_q;
    end
    close_run = cand_open && (!pass_q || last_point);
    span      = 16'(best_len_q - 10'd1) * 16'(STEP);
    centre    = 16'(best_start_q) + (span >> 1);
    {unused_centre_hi, centre_tap} = centre;
  end

  // NOTE: every next-state signal takes its hold value first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    tap_d         = tap_q;
    restore_d     = restore_q;
    delay_value_d = delay_value_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    fail_d        = fail_q;
    best_delay_d  = best_delay_q;
    eye_len_d     = eye_len_q;
    to_cnt_d      = to_cnt_q;
    cnt_d         = cnt_q;
    pass_d        = pass_q;
    run_open_d    = run_open_q;
    run_start_d   = run_start_q;
    run_len_d     = run_len_q;
    best_start_d  = best_start_q;
    best_len_d    = best_len_q;

    unique case (state_q)
      S_IDLE: if (start) begin
        restore_d    = delay_monitor;
        fail_d       = 1'b0;
        best_delay_d = '0;
        eye_len_d    = '0;
        run_open_d   = 1'b0;
        run_start_d  = '0;
        run_len_d    = '0;
        best_start_d = '0;
        best_len_d   = '0;
        tap_d        = '0;
        busy_d       = 1'b1;
        state_d      = S_SET;
      end
      S_SET: begin
        delay_value_d = tap_q;
        to_cnt_d      = '0;
        state_d       = S_APPLY;
      end
      S_APPLY: begin
        if (ready && delay_monitor == tap_q) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
          fail_d        = 1'b1;
          delay_value_d = restore_q;
          to_cnt_d      = '0;
          state_d       = S_FINAL;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          cnt_d   = '0;
          pass_d  = 1'b1;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        pass_d = pass_q & pattern_ok;
        if (cnt_q == CW'(SAMPLE - 1)) begin
          cnt_d   = '0;
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EVAL: begin
        run_open_d  = cand_open && !close_run;
        run_start_d = cand_start;
        run_len_d   = cand_len;
        // Strictly greater keeps the lowest-tap run on a tie.
        if (close_run && cand_len > best_len_q) begin
          best_start_d = cand_start;
          best_len_d   = cand_len;
        end
        if (last_point) begin
          state_d = S_CENTER;
        end else begin
          tap_d   = next_tap[8:0];
          state_d = S_SET;
        end
      end
      S_CENTER: begin
        if (best_len_q == '0) begin
          fail_d        = 1'b1;
          delay_value_d = restore_q;
        end else begin
          best_delay_d  = centre_tap;
          eye_len_d     = best_len_q;
          delay_value_d = centre_tap;
        end
        to_cnt_d = '0;
        state_d  = S_FINAL;
      end
      S_FINAL: begin
        if (ready && delay_monitor == delay_value_q) begin
          state_d = S_DONE;
        end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
          fail_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      tap_q         <= '0;
      restore_q     <= '0;
      delay_value_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
      best_delay_q  <= '0;
      eye_len_q     <= '0;
      to_cnt_q      <= '0;
      cnt_q         <= '0;
      pass_q        <= 1'b0;
      run_open_q    <= 1'b0;
      run_start_q   <= '0;
      run_len_q     <= '0;
      best_start_q  <= '0;
      best_len_q    <= '0;
    end else begin
      state_q       <= state_d;
      tap_q         <= tap_d;
      restore_q     <= restore_d;
      delay_value_q <= delay_value_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
      best_delay_q  <= best_delay_d;
      eye_len_q     <= eye_len_d;
      to_cnt_q      <= to_cnt_d;
      cnt_q         <= cnt_d;
      pass_q        <= pass_d;
      run_open_q    <= run_open_d;
      run_start_q   <= run_start_d;
      run_len_q     <= run_len_d;
      best_start_q  <= best_start_d;
      best_len_q    <= best_len_d;
    end
  end

  assign delay_value = delay_value_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign best_delay  = best_delay_q;
  assign eye_len     = eye_len_q;

endmodule

// File: tb/tb_delay_eye_scan.sv
// Bench for delay_eye_scan: behavioural delay controller plus pattern source, with a
// scoreboard of expected scan results popped when done pulses.
module tb_delay_eye_scan;

  localparam int STEP = 8, MAX_TAP = 511, SETTLE = 8, SAMPLE = 16, TIMEOUT = 4096;
  localparam int APPLY_LAT = 40;
  localparam int SCAN_BUDGET = 20000;

  logic       clk_125m = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ready, pattern_ok;
  logic [8:0] delay_monitor, delay_value, best_delay;
  logic       busy, done, fail;
  logic [9:0] eye_len;

  always #4 clk_125m = ~clk_125m;

  delay_eye_scan #(
    .STEP(STEP), .MAX_TAP(MAX_TAP), .SETTLE(SETTLE), .SAMPLE(SAMPLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_125m(clk_125m), .rst_n(rst_n), .start(start), .ready(ready),
    .delay_monitor(delay_monitor), .pattern_ok(pattern_ok), .delay_value(delay_value),
    .busy(busy), .done(done), .fail(fail), .best_delay(best_delay), .eye_len(eye_len)
  );

  // Controller model: retargets on any change of delay_value, applies after APPLY_LAT cycles.
  logic [8:0] req_q = '0, mon_q = '0, preset_val = '0;
  logic       rdy_q = 1'b1, stuck_q = 1'b0;
  logic       preset_en = 1'b0, stall_arm = 1'b0;
  int         lat_cnt = 0, cyc = 0, dwell16 = 0, mode = 0;

  always @(posedge clk_125m) begin
    cyc <= cyc + 1;
    if (!stall_arm) stuck_q <= 1'b0;
    else if (req_q == 9'd16) stuck_q <= 1'b1;
    if (!stall_arm) dwell16 <= 0;
    else if (delay_value == 9'd16) dwell16 <= dwell16 + 1;
    if (preset_en) begin
      mon_q <= preset_val;
    end else if (delay_value != req_q) begin
      req_q   <= delay_value;
      rdy_q   <= 1'b0;
      lat_cnt <= APPLY_LAT;
    end else if (!stuck_q && lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) begin
        mon_q <= req_q;
        rdy_q <= 1'b1;
      end
    end
  end

  // Outside the eye the checker drops out periodically, so any full window sees an error.
  function automatic logic pat_ok(input int m, input logic [8:0] tap, input int c);
    logic in_eye;
    case (m)
      0:       in_eye = (tap >= 80 && tap <= 200);
      1:       in_eye = (tap <= 48) || (tap >= 296 && tap <= 344);
      2:       in_eye = (tap >= 480 && tap <= 504);
      default: in_eye = 1'b0;
    endcase
    if (m == 3) return 1'b0;
    return in_eye || (c % 13 != 0);
  endfunction

  assign ready         = rdy_q;
  assign delay_monitor = mon_q;
  assign pattern_ok    = pat_ok(mode, mon_q, cyc);

  typedef struct {
    logic       fail;
    logic [8:0] best;
    logic [9:0] eye;
    logic [8:0] final_tap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0, n_pass = 0;

  task automatic pulse_start(input string name);
    @(negedge clk_125m);
    start = 1'b1;
    @(negedge clk_125m);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL %s busy_rise: got %b want 1", name, busy);
    else n_pass++;
  endtask

  task automatic wait_done(input string name);
    exp_t e;
    int   waited = 0;
    while (done !== 1'b1 && waited < SCAN_BUDGET) begin
      @(negedge clk_125m);
      waited++;
    end
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s scoreboard: no expected entry queued", name);
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (done !== 1'b1) begin
      $display("FAIL %s done_timeout: no done after %0d cycles", name, waited);
      return;
    end
    n_pass++;
    n_checks++;
    if (fail !== e.fail) $display("FAIL %s fail: got %b want %b", name, fail, e.fail);
    else n_pass++;
    n_checks++;
    if (best_delay !== e.best) $display("FAIL %s best_delay: got %0d want %0d", name, best_delay, e.best);
    else n_pass++;
    n_checks++;
    if (eye_len !== e.eye) $display("FAIL %s eye_len: got %0d want %0d", name, eye_len, e.eye);
    else n_pass++;
    n_checks++;
    if (delay_value !== e.final_tap) $display("FAIL %s delay_value: got %0d want %0d", name, delay_value, e.final_tap);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s busy_at_done: got %b want 0", name, busy);
    else n_pass++;
    @(negedge clk_125m);
    n_checks++;
    if (done !== 1'b0) $display("FAIL %s done_width: got %b want 0", name, done);
    else n_pass++;
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if (delay_value !== 9'd0) $display("FAIL %s delay_value: got %0d want 0", name, delay_value);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s busy: got %b want 0", name, busy);
    else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL %s done: got %b want 0", name, done);
    else n_pass++;
    n_checks++;
    if (fail !== 1'b0) $display("FAIL %s fail: got %b want 0", name, fail);
    else n_pass++;
    n_checks++;
    if (best_delay !== 9'd0) $display("FAIL %s best_delay: got %0d want 0", name, best_delay);
    else n_pass++;
    n_checks++;
    if (eye_len !== 10'd0) $display("FAIL %s eye_len: got %0d want 0", name, eye_len);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_125m);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk_125m);
  endtask

  task automatic test_basic_eye();
    mode = 0;
    sb.push_back('{1'b0, 9'd140, 10'd16, 9'd140});
    pulse_start("basic");
    wait_done("basic");
  endtask

  task automatic test_tie();
    mode = 1;
    sb.push_back('{1'b0, 9'd24, 10'd7, 9'd24});
    pulse_start("tie");
    wait_done("tie");
  endtask

  task automatic test_open_end();
    mode = 2;
    sb.push_back('{1'b0, 9'd492, 10'd4, 9'd492});
    pulse_start("open_end");
    wait_done("open_end");
  endtask

  task automatic test_no_eye();
    mode = 3;
    @(negedge clk_125m);
    preset_val = 9'd37;
    preset_en  = 1'b1;
    @(negedge clk_125m);
    preset_en  = 1'b0;
    sb.push_back('{1'b1, 9'd0, 10'd0, 9'd37});
    pulse_start("no_eye");
    wait_done("no_eye");
  endtask

  task automatic test_apply_timeout();
    mode = 0;
    stall_arm = 1'b1;
    sb.push_back('{1'b1, 9'd0, 10'd0, 9'd37});
    pulse_start("timeout");
    wait_done("timeout");
    n_checks++;
    if (dwell16 !== TIMEOUT) $display("FAIL timeout apply_cycles: got %0d want %0d", dwell16, TIMEOUT);
    else n_pass++;
    stall_arm = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    int waited = 0;
    logic [8:0] dv_before;
    mode = 0;
    pulse_start("midreset");
    while (!(delay_value == 9'd64 && delay_monitor == 9'd64 && ready) && waited < SCAN_BUDGET) begin
      @(negedge clk_125m);
      waited++;
    end
    n_checks++;
    if (waited >= SCAN_BUDGET) $display("FAIL midreset reach_tap64: not reached in %0d cycles", waited);
    else n_pass++;
    repeat (SETTLE + 4) @(negedge clk_125m);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (2) @(negedge clk_125m);
    rst_n = 1'b1;
    waited = 0;
    while (!(delay_monitor == 9'd0 && ready) && waited < 200) begin
      @(negedge clk_125m);
      waited++;
    end
    n_checks++;
    if (delay_monitor !== 9'd0) $display("FAIL midreset retarget0: got %0d want 0", delay_monitor);
    else n_pass++;

    sb.push_back('{1'b0, 9'd140, 10'd16, 9'd140});
    pulse_start("rescan");
    repeat (500) @(negedge clk_125m);
    dv_before = delay_value;
    start = 1'b1;
    @(negedge clk_125m);
    start = 1'b0;
    repeat (3) @(negedge clk_125m);
    n_checks++;
    if (dv_before == 9'd0 || delay_value == 9'd0)
      $display("FAIL rescan start_ignored: delay_value %0d -> %0d want nonzero", dv_before, delay_value);
    else n_pass++;
    wait_done("rescan");
  endtask

  initial begin
    test_reset();
    test_basic_eye();
    test_tie();
    test_open_end();
    test_no_eye();
    test_apply_timeout();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
